adc_spi_muestreo: RTL and testbench

- Upstream acquisition stage for the biquad IIR filter.
- Runs a fixed-rate sample timer and reads one 12-bit unsigned sample per period from an ADCS7476-style serial ADC: 16 clocks, 4 leading zeros, then D11..D0, MSB first.
- Converts each sample to the filter's signed fixed-point format (sign + mag integer bits + pf fraction bits, `size` total).
- Emits a one-cycle `EN` strobe that clocks the filter's delay registers.

---
 rtl/adc_spi_muestreo_if.sv | 42 ++++
 rtl/adc_spi_muestreo.sv | 199 +++++++++++++++++++
 tb/tb_adc_spi_muestreo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_muestreo_if.sv
// Bundles the serial ADC pins and the filter-facing sample outputs of adc_spi_muestreo.
// Latency: none, wires only.
// Backpressure: none; the filter side takes every EN strobe.
//
// Signals:
//   sdata  ADC serial data, driven by the ADC on sclk falling edges
//   cs_n   ADC chip select, active low
//   sclk   ADC serial clock, idles high
//   u      signed fixed-point sample for the filter input, held between updates
//   EN     one-cycle strobe marking a new value on u
//   err    one-cycle pulse when a frame's leading bits were not all zero
// Modports:
//   master  the acquisition block (drives cs_n/sclk/u/EN/err, reads sdata)
//   slave   the ADC plus filter side (drives sdata, reads the rest)
interface adc_spi_muestreo_if #(
  parameter int size = 19
);
  logic            sdata;
  logic            cs_n;
  logic            sclk;
  logic [size-1:0] u;
  logic            EN;
  logic            err;

  modport master (
    input  sdata,
    output cs_n,
    output sclk,
    output u,
    output EN,
    output err
  );

  modport slave (
    output sdata,
    input  cs_n,
    input  sclk,
    input  u,
    input  EN,
    input  err
  );
endinterface

// File: rtl/adc_spi_muestreo.sv
// Timed serial-ADC acquisition: one 16-clock frame per sample period, converted to signed fixed point.
// Latency: u/EN update 1 + clk_div + 32*clk_div + 1 clk edges after the frame-start (timer wrap) edge.
// Backpressure: none; EN is a single-cycle strobe at most once per sample period.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset, overrides everything including a frame in flight
//   bus   adc_spi_muestreo_if.master: sdata in; cs_n, sclk, u, EN, err out (all registered)
// Parameters:
//   size        output word width
//   pf          output fraction bits (adc_bits-1 <= pf)
//   adc_bits    ADC data bits inside the 16-bit frame
//   clk_div     clk cycles per sclk half-period (>= 1)
//   sample_div  clk cycles per sample period (>= 33*clk_div+4)
module adc_spi_muestreo #(
  parameter int size       = 19,
  parameter int pf         = 14,
  parameter int adc_bits   = 12,
  parameter int clk_div    = 4,
  parameter int sample_div = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_spi_muestreo_if.master   bus
);

  localparam int TW = (sample_div > 2) ? $clog2(sample_div) : 1;
  localparam int CW = $clog2(clk_div + 1) + 1;
  // Left shift that places the ADC MSB weight at 2^-1 relative to the output LSB grid,
  // so full scale lands on [-1.0, +1.0).
  localparam int SH = pf - adc_bits + 1;

  localparam logic [TW-1:0] TIMER_MAX = TW'(sample_div - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(clk_div);
  localparam logic [CW-1:0] HALF_END  = CW'(clk_div - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registered state
  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      bitcnt, bitcnt_n;
  logic [15:0]     shift, shift_n;
  logic            cs_n_q, cs_n_n;
  logic            sclk_q, sclk_n;
  logic [size-1:0] u_q, u_n;
  logic            en_q, en_n;
  logic            err_q, err_n;

  // Conversion datapath (purely from the shift register, evaluated in DONE)
  logic                  wrap;
  logic [adc_bits-1:0]   d;
  logic [adc_bits-1:0]   s;
  logic [15-adc_bits:0]  lead;
  logic signed [size-1:0] ext;
  logic signed [size-1:0] conv;

  // ---------------------------------------------------------------------------
  // Sample timer: free-running in every state, the wrap marks a frame start.
  // ---------------------------------------------------------------------------
  always_comb begin
    wrap    = (timer == TIMER_MAX);
    timer_n = wrap ? '0 : timer + TW'(1);
  end

  // ---------------------------------------------------------------------------
  // Offset-binary to two's complement: flipping the MSB maps mid-scale to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    d    = shift[adc_bits-1:0];
    lead = shift[15:adc_bits];
    s    = {~d[adc_bits-1], d[adc_bits-2:0]};
    ext  = {{(size-adc_bits){s[adc_bits-1]}}, s};
    conv = ext <<< SH;
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is a register, so the pins
  // see these values one edge later and sdata never reaches a pin directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    cs_n_n   = cs_n_q;
    sclk_n   = sclk_q;
    u_n      = u_q;
    en_n     = 1'b0;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b1;
        if (wrap) begin
          state_n  = SETUP;
          cs_n_n   = 1'b0;
          cnt_n    = '0;
          bitcnt_n = '0;
        end
      end

      SETUP: begin
        // cs_n low with sclk parked high; the count starts at the frame-start
        // edge, so the first sclk fall comes clk_div+1 edges after cs_n falls.
        if (cnt == SETUP_END) begin
          state_n = SHIFT;
          sclk_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (!sclk_q) begin
            // End of low phase: raise sclk and sample the bit the ADC
            // presented on the preceding falling edge.
            sclk_n  = 1'b1;
            shift_n = {shift[14:0], bus.sdata};
          end else if (bitcnt == 4'd15) begin
            // 16th high phase complete: release the ADC, sclk stays high.
            state_n = DONE;
            cs_n_n  = 1'b1;
          end else begin
            sclk_n   = 1'b0;
            bitcnt_n = bitcnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
        if (lead == '0) begin
          u_n  = conv;
          en_n = 1'b1;
        end else begin
          // Framing fault: keep the last good sample and flag it instead.
          err_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous reset; reset aborts any frame in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b1;
      u_q    <= '0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      cs_n_q <= cs_n_n;
      sclk_q <= sclk_n;
      u_q    <= u_n;
      en_q   <= en_n;
      err_q  <= err_n;
    end
  end

  assign bus.cs_n = cs_n_q;
  assign bus.sclk = sclk_q;
  assign bus.u    = u_q;
  assign bus.EN   = en_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_adc_spi_muestreo.sv
// Bench for adc_spi_muestreo with a behavioural serial ADC and a result scoreboard.
// Latency: expects results 68 clk edges after each cs_n fall (clk_div=2).
// Backpressure: none exercised; the DUT has no ready input.
module tb_adc_spi_muestreo;

  localparam int SIZE = 19;
  localparam int PF   = 14;
  localparam int AB   = 12;
  localparam int CD   = 2;
  localparam int SD   = 80;
  localparam int LAT  = 1 + CD + 32 * CD + 1;

  typedef struct {
    logic [15:0]     word;
    logic [SIZE-1:0] exp_u;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] u;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_spi_muestreo_if #(.size(SIZE)) bus ();

  adc_spi_muestreo #(
    .size(SIZE), .pf(PF), .adc_bits(AB), .clk_div(CD), .sample_div(SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t stim_q[$];
  exp_t exp_q[$];
  vec_t tbl[8];

  int total = 0;
  int bad   = 0;
  int edge_no = 0;
  int cs_fall_edge = 0;
  int rise_cnt = 0;
  int expect_rises = 16;
  bit ramp_mode = 1'b0;
  bit ramp_first = 1'b1;
  logic signed [SIZE-1:0] ramp_last = '0;
  logic p_cs = 1'b1;
  logic p_sclk = 1'b1;
  logic p_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  // Reference conversion: offset binary around 2048, scaled by 2^(pf-adc_bits+1) = 8.
  function automatic logic [SIZE-1:0] conv_u(input logic [11:0] dv);
    int v;
    v = (int'(dv) - 2048) * 8;
    return SIZE'(v);
  endfunction

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: timeout, stim left %0d expected left %0d", name, stim_q.size(), exp_q.size());
    end
  endtask

  initial forever #5 clk = ~clk;

  // Edge numbering: 0 while reset is sampled, then 1, 2, ... per rising edge.
  initial forever begin
    @(posedge clk);
    if (rst) edge_no = 0;
    else     edge_no = edge_no + 1;
  end

  // ADC model: one frame per cs_n fall, next bit on each sclk fall, MSB first.
  // The expected result is queued as the frame's data is committed.
  initial begin
    vec_t cur;
    exp_t e;
    int idx;
    bus.sdata = 1'b0;
    forever begin
      @(negedge bus.cs_n);
      if (stim_q.size() > 0) begin
        cur = stim_q.pop_front();
      end else begin
        cur.word    = 16'h0000;
        cur.exp_u   = conv_u(12'h000);
        cur.exp_err = 1'b0;
      end
      e.u   = cur.exp_u;
      e.err = cur.exp_err;
      exp_q.push_back(e);
      idx = 15;
      bus.sdata = 1'b0;
      while (bus.cs_n === 1'b0) begin
        @(negedge bus.sclk or posedge bus.cs_n);
        if (bus.cs_n === 1'b0 && idx >= 0) begin
          bus.sdata = cur.word[idx];
          idx--;
        end
      end
    end
  end

  // Monitor: framing, sclk edge count, strobe width and scoreboard compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (p_en === 1'b1) check("en_width", {31'd0, bus.EN}, 32'd0);
      if (p_cs === 1'b1 && bus.cs_n === 1'b0) begin
        cs_fall_edge = edge_no;
        rise_cnt = 0;
        check("frame_phase", edge_no % SD, 0);
      end
      if (bus.cs_n === 1'b0 && p_sclk === 1'b0 && bus.sclk === 1'b1) rise_cnt++;
      if (p_cs === 1'b0 && bus.cs_n === 1'b1) begin
        check("sclk_rises", rise_cnt, expect_rises);
        expect_rises = 16;
      end
      if (bus.EN === 1'b1 || bus.err === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: EN=%0b err=%0b u=%0h with no frame pending", bus.EN, bus.err, bus.u);
        end else begin
          e = exp_q.pop_front();
          check("err_flag", {31'd0, bus.err}, {31'd0, e.err});
          check("en_flag", {31'd0, bus.EN}, {31'd0, ~e.err});
          check("u_value", 32'(bus.u), 32'(e.u));
          check("latency", edge_no - cs_fall_edge, LAT);
          if (ramp_mode && bus.EN === 1'b1) begin
            if (!ramp_first)
              check("ramp_monotonic", {31'd0, ($signed(bus.u) > ramp_last)}, 32'd1);
            ramp_first = 1'b0;
            ramp_last  = $signed(bus.u);
          end
        end
      end
      p_cs   = bus.cs_n;
      p_sclk = bus.sclk;
      p_en   = bus.EN;
    end
  end

  initial begin
    vec_t v;
    int n;
    tbl[0] = '{16'h0000, 19'h7C000, 1'b0};
    tbl[1] = '{16'h0800, 19'h00000, 1'b0};
    tbl[2] = '{16'h0FFF, 19'h03FF8, 1'b0};
    tbl[3] = '{16'h0001, 19'h7C008, 1'b0};
    tbl[4] = '{16'h2123, 19'h7C008, 1'b1};
    tbl[5] = '{16'h0ABC, 19'h015E0, 1'b0};
    tbl[6] = '{16'hF000, 19'h015E0, 1'b1};
    tbl[7] = '{16'h0400, 19'h7E000, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("rst_sclk", {31'd0, bus.sclk}, 32'd1);
    check("rst_u",    32'(bus.u), 32'd0);
    check("rst_en",   {31'd0, bus.EN}, 32'd0);
    check("rst_err",  {31'd0, bus.err}, 32'd0);
    rst = 1'b0;

    // Table-driven frames, including framing errors that must hold u
    for (int i = 0; i < 8; i++) stim_q.push_back(tbl[i]);
    wait_drained("table_drain", 10 * SD + 200);

    // Reset in the middle of SHIFT, after the 8th sclk rise
    v.word = 16'h0555; v.exp_u = conv_u(12'h555); v.exp_err = 1'b0;
    stim_q.push_back(v);
    n = 0;
    while (stim_q.size() > 0 && n < 3 * SD) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    n = 0;
    while (rise_cnt < 8 && n < 3 * SD) begin @(negedge clk); n++; end
    total++;
    if (n >= 3 * SD) begin
      bad++;
      $display("FAIL midreset_wait: 8th sclk rise not seen, rises %0d", rise_cnt);
    end
    expect_rises = 8;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, bus.sclk}, 32'd1);
    check("midrst_u",    32'(bus.u), 32'd0);
    check("midrst_en",   {31'd0, bus.EN}, 32'd0);
    check("midrst_err",  {31'd0, bus.err}, 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());

    // Ramp across the full code range
    ramp_first = 1'b1;
    ramp_mode  = 1'b1;
    for (int dv = 0; dv < 4096; dv += 64) begin
      v.word = {4'b0000, 12'(dv)}; v.exp_u = conv_u(12'(dv)); v.exp_err = 1'b0;
      stim_q.push_back(v);
    end
    v.word = 16'h0FFF; v.exp_u = conv_u(12'hFFF); v.exp_err = 1'b0;
    stim_q.push_back(v);
    wait_drained("ramp_drain", 68 * SD + 400);
    ramp_mode = 1'b0;
    check("ramp_last_u", 32'(ramp_last), 32'(19'h03FF8));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
